// File: rtl/sample_ticks_to_midi_note_if.sv
// Handshake bundle between the period detector, the period-to-note converter and its consumer.
// Both sides follow valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface sample_ticks_to_midi_note_if #(
  parameter int TICK_W = 24
);
  logic                     in_valid;
  logic                     in_ready;
  logic [TICK_W-1:0]        period_ticks;
  logic                     out_valid;
  logic                     out_ready;
  logic [6:0]               note;
  logic signed [TICK_W:0]   deviation;
  logic                     below_range;
  logic                     above_range;
  logic                     err_zero;

  modport master (
    output in_valid, period_ticks, out_ready,
    input  in_ready, out_valid, note, deviation, below_range, above_range, err_zero
  );

  modport slave (
    input  in_valid, period_ticks, out_ready,
    output in_ready, out_valid, note, deviation, below_range, above_range, err_zero
  );
endinterface

// File: rtl/sample_ticks_to_midi_note.sv
// Converts a pitch period in 195.3125 kHz ticks to the nearest MIDI note using a 7-step
// successive-approximation search over a period ROM, one ROM read per cycle.
module sample_ticks_to_midi_note #(
  parameter int TICK_W = 24
) (
  input  logic                          clk,
  input  logic                          reset,
  sample_ticks_to_midi_note_if.slave    io_bus,
  output logic [1:0]                    o_state
);
  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_NEAR, S_DONE} state_t;

  // T[n] = floor(195312.5 / (440 * 2^((n-69)/12))), strictly decreasing
  localparam int unsigned T_ROM [128] = '{
    23889, 22548, 21282, 20088, 18960, 17896, 16892, 15944, 15049, 14204,
    13407, 12654, 11944, 11274, 10641, 10044,  9480,  8948,  8446,  7972,
     7524,  7102,  6703,  6327,  5972,  5637,  5320,  5022,  4740,  4474,
     4223,  3986,  3762,  3551,  3351,  3163,  2986,  2818,  2660,  2511,
     2370,  2237,  2111,  1993,  1881,  1775,  1675,  1581,  1493,  1409,
     1330,  1255,  1185,  1118,  1055,   996,   940,   887,   837,   790,
      746,   704,   665,   627,   592,   559,   527,   498,   470,   443,
      418,   395,   373,   352,   332,   313,   296,   279,   263,   249,
      235,   221,   209,   197,   186,   176,   166,   156,   148,   139,
      131,   124,   117,   110,   104,    98,    93,    88,    83,    78,
       74,    69,    65,    62,    58,    55,    52,    49,    46,    44,
       41,    39,    37,    34,    32,    31,    29,    27,    26,    24,
       23,    22,    20,    19,    18,    17,    16,    15
  };

  localparam logic [TICK_W-1:0] T_FIRST = TICK_W'(T_ROM[0]);
  localparam logic [TICK_W-1:0] T_LAST  = TICK_W'(T_ROM[127]);

  function automatic logic [TICK_W-1:0] rom_rd(input logic [6:0] idx);
    return TICK_W'(T_ROM[idx]);
  endfunction

  state_t                 r_state, w_state_nxt;
  logic [TICK_W-1:0]      r_p;
  logic [6:0]             r_n;
  logic [2:0]             r_bit;
  logic [TICK_W-1:0]      r_t_lo;
  logic [TICK_W-1:0]      r_t_hi;
  logic                   r_has_hi;
  logic [6:0]             r_note;
  logic signed [TICK_W:0] r_dev;
  logic                   r_below, r_above, r_zero;

  logic [6:0]             w_c;
  logic [TICK_W-1:0]      w_t_c;
  logic                   w_take;
  logic                   w_pick_hi;
  logic [6:0]             w_note;
  logic [TICK_W-1:0]      w_t_sel;
  logic signed [TICK_W:0] w_dev;
  logic                   w_zero, w_below, w_above;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (io_bus.in_valid)  w_state_nxt = S_SEARCH;
      S_SEARCH: if (r_bit == 3'd0)    w_state_nxt = S_NEAR;
      S_NEAR:                         w_state_nxt = S_DONE;
      S_DONE:   if (io_bus.out_ready) w_state_nxt = S_IDLE;
      default:                        w_state_nxt = S_IDLE;
    endcase
  end

  assign w_c    = r_n | (7'd1 << r_bit);
  assign w_t_c  = rom_rd(w_c);
  assign w_take = (w_t_c >= r_p);

  // r_t_lo holds T[n] (last accepted probe); r_t_hi holds T[n+1], which is always the last rejected probe.
  always_comb begin
    w_zero    = (r_p == '0);
    w_below   = (r_p > T_FIRST);
    w_above   = !w_zero && (r_p < T_LAST);
    w_pick_hi = r_has_hi && ((r_p - r_t_hi) < (r_t_lo - r_p));
    w_note    = r_n;
    w_t_sel   = r_t_lo;
    if (w_pick_hi) begin
      w_note  = r_n + 7'd1;
      w_t_sel = r_t_hi;
    end
    if (r_p >= T_FIRST) begin
      w_note  = 7'd0;
      w_t_sel = T_FIRST;
    end
    if (r_p <= T_LAST) begin
      w_note  = 7'd127;
      w_t_sel = T_LAST;
    end
    w_dev = $signed({1'b0, r_p}) - $signed({1'b0, w_t_sel});
    if (w_zero) begin
      w_note = 7'd0;
      w_dev  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_p      <= '0;
      r_n      <= '0;
      r_bit    <= '0;
      r_t_lo   <= '0;
      r_t_hi   <= '0;
      r_has_hi <= 1'b0;
      r_note   <= '0;
      r_dev    <= '0;
      r_below  <= 1'b0;
      r_above  <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (io_bus.in_valid) begin
          r_p      <= io_bus.period_ticks;
          r_n      <= '0;
          r_bit    <= 3'd6;
          r_t_lo   <= T_FIRST;
          r_has_hi <= 1'b0;
          r_below  <= 1'b0;
          r_above  <= 1'b0;
          r_zero   <= 1'b0;
        end
        S_SEARCH: begin
          if (w_take) begin
            r_n    <= w_c;
            r_t_lo <= w_t_c;
          end else begin
            r_t_hi   <= w_t_c;
            r_has_hi <= 1'b1;
          end
          r_bit <= r_bit - 3'd1;
        end
        S_NEAR: begin
          r_note  <= w_note;
          r_dev   <= w_dev;
          r_below <= w_below;
          r_above <= w_above;
          r_zero  <= w_zero;
        end
        default: ;
      endcase
    end
  end

  assign io_bus.in_ready    = (r_state == S_IDLE);
  assign io_bus.out_valid   = (r_state == S_DONE);
  assign io_bus.note        = r_note;
  assign io_bus.deviation   = r_dev;
  assign io_bus.below_range = r_below;
  assign io_bus.above_range = r_above;
  assign io_bus.err_zero    = r_zero;
  assign o_state            = r_state;
endmodule

// File: tb/tb_sample_ticks_to_midi_note.sv
// Bench for the period-to-note converter: vector table, model-based sweep and random runs,
// plus hand-written backpressure, latency and mid-search reset sequences.
module tb_sample_ticks_to_midi_note;
  localparam int TICK_W = 24;
  localparam int W      = 7 + TICK_W + 1 + 3;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] dbg_state;
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int acc_cyc = 0;
  int t_tab [128];
  logic [W-1:0] exp_q [$];

  sample_ticks_to_midi_note_if #(.TICK_W(TICK_W)) bus ();

  sample_ticks_to_midi_note #(.TICK_W(TICK_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .io_bus  (bus),
    .o_state (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [TICK_W-1:0] p;
    int                note;
    int                dev;
    logic [2:0]        flags;  // {below, above, zero}
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  function automatic logic [W-1:0] pack(input int note, input int dev, input logic [2:0] flags);
    logic [TICK_W:0] d;
    d = (TICK_W+1)'(dev);
    return {7'(note), d, flags};
  endfunction

  function automatic int t_model(input int n);
    real v;
    v = 195312.5 / (440.0 * $pow(2.0, (n - 69) / 12.0));
    return $rtoi($floor(v));
  endfunction

  // Reference: linear scan for the largest n with T[n] >= P, then nearest-of-two with ties low.
  function automatic logic [W-1:0] model_exp(input int p);
    int n;
    int note;
    if (p == 0) return pack(0, 0, 3'b001);
    if (p >= t_tab[0])   return pack(0, p - t_tab[0], {p > t_tab[0], 2'b00});
    if (p <= t_tab[127]) return pack(127, p - t_tab[127], {1'b0, p < t_tab[127], 1'b0});
    n = 0;
    for (int k = 0; k < 128; k++) if (t_tab[k] >= p) n = k;
    note = n;
    if (n < 127 && (p - t_tab[n+1]) < (t_tab[n] - p)) note = n + 1;
    return pack(note, p - t_tab[note], 3'b000);
  endfunction

  // Scoreboard: every accepted output transfer is compared against the head of exp_q.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: note %0d with empty expected queue", bus.note);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("note", int'(bus.note), int'(e[W-1 -: 7]));
        chk("deviation", int'(bus.deviation), int'($signed(e[TICK_W+3 -: TICK_W+1])));
        chk("flags", int'({bus.below_range, bus.above_range, bus.err_zero}), int'(e[2:0]));
      end
    end
  end

  task automatic wait_in_ready();
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) fail_timeout("in_ready_wait");
  endtask

  task automatic send(input logic [TICK_W-1:0] p, input logic [W-1:0] e, input bit push);
    wait_in_ready();
    bus.period_ticks = p;
    bus.in_valid     = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      fail_timeout("result_wait");
      exp_q.delete();
    end
  endtask

  initial begin
    int cnt;
    int prev;
    for (int n = 0; n < 128; n++) t_tab[n] = t_model(n);
    vecs[0] = '{24'd443,   69,     0, 3'b000};
    vecs[1] = '{24'd23889,  0,     0, 3'b000};
    vecs[2] = '{24'd30000,  0,  6111, 3'b100};
    vecs[3] = '{24'd15,   127,     0, 3'b000};
    vecs[4] = '{24'd10,   127,    -5, 3'b010};
    vecs[5] = '{24'd0,      0,     0, 3'b001};
    vecs[6] = '{24'd768,   59,   -22, 3'b000};
    vecs[7] = '{24'd767,   60,    21, 3'b000};
    vecs[8] = '{24'd790,   59,     0, 3'b000};
    vecs[9] = '{24'd746,   60,     0, 3'b000};

    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.period_ticks = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", int'(bus.in_ready), 1);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_note", int'(bus.note), 0);
    chk("reset_dev", int'(bus.deviation), 0);
    chk("reset_flags", int'({bus.below_range, bus.above_range, bus.err_zero}), 0);
    chk("reset_state", int'(dbg_state), 0);

    // Latency from accept edge to the first edge that sees out_valid
    send(24'd443, pack(69, 0, 3'b000), 1'b1);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus.out_valid && cnt < 20);
    chk("latency", cnt, 9);
    wait_drain();

    for (int i = 0; i < 10; i++) begin
      send(vecs[i].p, pack(vecs[i].note, vecs[i].dev, vecs[i].flags), 1'b1);
      wait_drain();
    end

    // Backpressure: result must hold while a second request waits
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(24'd704, pack(61, 0, 3'b000), 1'b1);
    cnt = 0;
    while (!bus.out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (!bus.out_valid) fail_timeout("bp_out_valid");
    bus.period_ticks = 24'd443;
    bus.in_valid = 1'b1;
    exp_q.push_back(pack(69, 0, 3'b000));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_note", int'(bus.note), 61);
      chk("bp_dev", int'(bus.deviation), 0);
      chk("bp_in_ready", int'(bus.in_ready), 0);
      chk("bp_out_valid", int'(bus.out_valid), 1);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (bus.in_ready && cnt < 20) ;
    bus.in_valid = 1'b0;
    wait_drain();

    // Reset during the fourth search cycle abandons the period
    send(24'd1000, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_state", int'(dbg_state), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_reset_state", int'(dbg_state), 0);
    chk("mid_reset_out_valid", int'(bus.out_valid), 0);
    chk("mid_reset_note", int'(bus.note), 0);
    chk("mid_reset_in_ready", int'(bus.in_ready), 1);
    chk("mid_reset_dev", int'(bus.deviation), 0);
    reset = 1'b0;

    // Sweep every ROM value with out_ready held: also checks 10-cycle throughput
    prev = 0;
    for (int n = 0; n < 128; n++) begin
      send(TICK_W'(t_tab[n]), model_exp(t_tab[n]), 1'b1);
      if (n > 0) chk("throughput", acc_cyc - prev, 10);
      prev = acc_cyc;
    end
    wait_drain();

    for (int i = 0; i < 40; i++) begin
      int p;
      p = (i % 4 == 0) ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 30000));
      send(TICK_W'(p), model_exp(p), 1'b1);
    end
    wait_drain();

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
